// File: rtl/rv32i_pkg.sv
// RV32I shared decode definitions: opcodes, ALU op codes, immediate formats,
// result-select codes and the canonical NOP.
package rv32i_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [31:0] RV_NOP = 32'h00000013;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_PASSB = 4'd10
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_src_e;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic       alu_src;
        alu_ctrl_e  alu_ctrl;
        logic       jalr;
        imm_src_e   imm_src;
        logic       imm_en;
    } ctrl_t;

    // funct7[5] selects SUB only for register-register ops; shifts honour it for both.
    function automatic alu_ctrl_e alu_decode(input logic [2:0] funct3,
                                             input logic       f7b5,
                                             input logic       is_reg);
        case (funct3)
            3'b000:  return (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic alu_ctrl_e branch_decode(input logic [2:0] funct3);
        case (funct3)
            3'b100, 3'b101: return ALU_SLT;
            3'b110, 3'b111: return ALU_SLTU;
            default:        return ALU_SUB;
        endcase
    endfunction

endpackage

// File: rtl/regfile_32x32.sv
// 32x32 integer register file: async reset, one write port, two async read
// ports with write-first bypass; x0 always reads zero.
module regfile_32x32
    import rv32i_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);

    logic [31:0] regs [DEPTH];
    logic        wr_hit;

    assign wr_hit = we && (wa != 5'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_hit) begin
            regs[wa] <= wd;
        end
    end

    // Same-cycle write data is forwarded so decode sees the value being retired.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (ra1 != 5'd0) begin
            rd1 = (wr_hit && (wa == ra1)) ? wd : regs[ra1];
        end
        if (ra2 != 5'd0) begin
            rd2 = (wr_hit && (wa == ra2)) ? wd : regs[ra2];
        end
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: IF/ID register, control decode, immediate generation and
// register file. Optional ID_ILLEGAL_DETECT_EN adds IllegalD and masks control.
module id_stage
    import rv32i_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = RV_NOP,
    parameter int          RF_DEPTH  = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic [31:0] InstrF,
    input  logic [31:0] PCF,
    input  logic [31:0] PCPlus4F,
    input  logic        RegWriteW,
    input  logic [4:0]  RdW,
    input  logic [31:0] ResultW,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic [4:0]  Rs1D,
    output logic [4:0]  Rs2D,
    output logic [4:0]  RdD,
    output logic [31:0] RD1D,
    output logic [31:0] RD2D,
    output logic [31:0] ImmExtD,
    output logic        RegWriteD,
    output logic [1:0]  ResultSrcD,
    output logic        MemWriteD,
    output logic        JumpD,
    output logic        BranchD,
    output logic        ALUSrcD,
    output logic [3:0]  ALUControlD,
    output logic        JalrD
`ifdef ID_ILLEGAL_DETECT_EN
    ,
    output logic        IllegalD
`endif
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    ctrl_t      ctrl_raw;
    ctrl_t      ctrl;

    // IF/ID register: flush beats stall beats load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
        end else if (FlushD) begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
        end else if (!StallD) begin
            InstrD   <= InstrF;
            PCD      <= PCF;
            PCPlus4D <= PCPlus4F;
        end
    end

    assign opcode = InstrD[6:0];
    assign funct3 = InstrD[14:12];
    assign Rs1D   = InstrD[19:15];
    assign Rs2D   = InstrD[24:20];
    assign RdD    = InstrD[11:7];

    // Unsupported opcodes, FENCE and SYSTEM fall through with every control bit low.
    always_comb begin
        ctrl_raw         = '0;
        ctrl_raw.imm_src = IMM_I;
        case (opcode)
            OP_LUI: begin
                ctrl_raw.reg_write = 1'b1;
                ctrl_raw.alu_src   = 1'b1;
                ctrl_raw.alu_ctrl  = ALU_PASSB;
                ctrl_raw.imm_src   = IMM_U;
                ctrl_raw.imm_en    = 1'b1;
            end
            OP_AUIPC: begin
                ctrl_raw.reg_write = 1'b1;
                ctrl_raw.alu_src   = 1'b1;
                ctrl_raw.alu_ctrl  = ALU_ADD;
                ctrl_raw.imm_src   = IMM_U;
                ctrl_raw.imm_en    = 1'b1;
            end
            OP_JAL: begin
                ctrl_raw.reg_write  = 1'b1;
                ctrl_raw.result_src = RES_PC4;
                ctrl_raw.jump       = 1'b1;
                ctrl_raw.imm_src    = IMM_J;
                ctrl_raw.imm_en     = 1'b1;
            end
            OP_JALR: begin
                ctrl_raw.reg_write  = 1'b1;
                ctrl_raw.result_src = RES_PC4;
                ctrl_raw.jump       = 1'b1;
                ctrl_raw.jalr       = 1'b1;
                ctrl_raw.alu_src    = 1'b1;
                ctrl_raw.imm_en     = 1'b1;
            end
            OP_BRANCH: begin
                ctrl_raw.branch   = 1'b1;
                ctrl_raw.alu_ctrl = branch_decode(funct3);
                ctrl_raw.imm_src  = IMM_B;
                ctrl_raw.imm_en   = 1'b1;
            end
            OP_LOAD: begin
                ctrl_raw.reg_write  = 1'b1;
                ctrl_raw.result_src = RES_MEM;
                ctrl_raw.alu_src    = 1'b1;
                ctrl_raw.imm_en     = 1'b1;
            end
            OP_STORE: begin
                ctrl_raw.mem_write = 1'b1;
                ctrl_raw.alu_src   = 1'b1;
                ctrl_raw.imm_src   = IMM_S;
                ctrl_raw.imm_en    = 1'b1;
            end
            OP_IMM: begin
                ctrl_raw.reg_write = 1'b1;
                ctrl_raw.alu_src   = 1'b1;
                ctrl_raw.alu_ctrl  = alu_decode(funct3, InstrD[30], 1'b0);
                ctrl_raw.imm_en    = 1'b1;
            end
            OP_REG: begin
                ctrl_raw.reg_write = 1'b1;
                ctrl_raw.alu_ctrl  = alu_decode(funct3, InstrD[30], 1'b1);
            end
            default: ;
        endcase
    end

`ifdef ID_ILLEGAL_DETECT_EN
    logic [6:0] funct7;
    logic       illegal;

    assign funct7 = InstrD[31:25];

    always_comb begin
        illegal = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL, OP_FENCE, OP_SYSTEM: illegal = 1'b0;
            OP_JALR:   illegal = (funct3 != 3'b000);
            OP_BRANCH: illegal = (funct3[2:1] == 2'b01);
            OP_LOAD:   illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            OP_STORE:  illegal = (funct3 > 3'b010);
            OP_IMM: begin
                if (funct3 == 3'b001) begin
                    illegal = (funct7 != 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                end
            end
            OP_REG: begin
                illegal = !((funct7 == 7'b0000000) ||
                            ((funct7 == 7'b0100000) &&
                             ((funct3 == 3'b000) || (funct3 == 3'b101))));
            end
            default: illegal = 1'b1;
        endcase
    end

    assign ctrl     = illegal ? ctrl_t'('0) : ctrl_raw;
    assign IllegalD = illegal;
`else
    assign ctrl = ctrl_raw;
`endif

    // B and J immediates carry an implicit zero LSB
    always_comb begin
        ImmExtD = '0;
        if (ctrl_raw.imm_en) begin
            case (ctrl_raw.imm_src)
                IMM_I: ImmExtD = {{20{InstrD[31]}}, InstrD[31:20]};
                IMM_S: ImmExtD = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
                IMM_B: ImmExtD = {{19{InstrD[31]}}, InstrD[31], InstrD[7],
                                  InstrD[30:25], InstrD[11:8], 1'b0};
                IMM_U: ImmExtD = {InstrD[31:12], 12'b0};
                IMM_J: ImmExtD = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12],
                                  InstrD[20], InstrD[30:21], 1'b0};
                default: ImmExtD = '0;
            endcase
        end
    end

    assign RegWriteD   = ctrl.reg_write;
    assign ResultSrcD  = ctrl.result_src;
    assign MemWriteD   = ctrl.mem_write;
    assign JumpD       = ctrl.jump;
    assign BranchD     = ctrl.branch;
    assign ALUSrcD     = ctrl.alu_src;
    assign ALUControlD = ctrl.alu_ctrl;
    assign JalrD       = ctrl.jalr;

    regfile_32x32 #(
        .DEPTH(RF_DEPTH)
    ) u_rf (
        .clk   (clk),
        .reset (reset),
        .we    (RegWriteW),
        .wa    (RdW),
        .wd    (ResultW),
        .ra1   (Rs1D),
        .ra2   (Rs2D),
        .rd1   (RD1D),
        .rd2   (RD2D)
    );

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: IF/ID stall/flush, decode, immediates, register
// file bypass and async reset; honours ID_ILLEGAL_DETECT_EN when defined.
module tb_id_stage;
    import rv32i_pkg::*;

    logic        clk;
    logic        reset;
    logic        StallD, FlushD;
    logic [31:0] InstrF, PCF, PCPlus4F;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic [31:0] RD1D, RD2D, ImmExtD;
    logic        RegWriteD;
    logic [1:0]  ResultSrcD;
    logic        MemWriteD, JumpD, BranchD, ALUSrcD, JalrD;
    logic [3:0]  ALUControlD;
`ifdef ID_ILLEGAL_DETECT_EN
    logic        IllegalD;
`endif

    int vectors     = 0;
    int miscompares = 0;

    id_stage dut (
        .clk         (clk),
        .reset       (reset),
        .StallD      (StallD),
        .FlushD      (FlushD),
        .InstrF      (InstrF),
        .PCF         (PCF),
        .PCPlus4F    (PCPlus4F),
        .RegWriteW   (RegWriteW),
        .RdW         (RdW),
        .ResultW     (ResultW),
        .InstrD      (InstrD),
        .PCD         (PCD),
        .PCPlus4D    (PCPlus4D),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .RdD         (RdD),
        .RD1D        (RD1D),
        .RD2D        (RD2D),
        .ImmExtD     (ImmExtD),
        .RegWriteD   (RegWriteD),
        .ResultSrcD  (ResultSrcD),
        .MemWriteD   (MemWriteD),
        .JumpD       (JumpD),
        .BranchD     (BranchD),
        .ALUSrcD     (ALUSrcD),
        .ALUControlD (ALUControlD),
        .JalrD       (JalrD)
`ifdef ID_ILLEGAL_DETECT_EN
        ,
        .IllegalD    (IllegalD)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] instr);
        InstrF = instr;
        step();
    endtask

    initial begin
        reset = 1'b1; StallD = 1'b0; FlushD = 1'b0;
        InstrF = '0; PCF = '0; PCPlus4F = '0;
        RegWriteW = 1'b0; RdW = '0; ResultW = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_instr", InstrD, 32'h00000013);
        chk("rst_pc", PCD, 32'h0);
        chk("rst_pc4", PCPlus4D, 32'h0);
        chk("rst_regwrite", 32'(RegWriteD), 32'd1);
        chk("rst_rd", 32'(RdD), 32'd0);
`ifdef ID_ILLEGAL_DETECT_EN
        chk("rst_illegal", 32'(IllegalD), 32'd0);
`endif
        @(negedge clk) reset = 1'b0;

        // addi x1,x0,5
        PCF = 32'h0; PCPlus4F = 32'h4;
        load(32'h00500093);
        chk("addi_instr", InstrD, 32'h00500093);
        chk("addi_regwrite", 32'(RegWriteD), 32'd1);
        chk("addi_alusrc", 32'(ALUSrcD), 32'd1);
        chk("addi_aluctl", 32'(ALUControlD), 32'(ALU_ADD));
        chk("addi_rd", 32'(RdD), 32'd1);
        chk("addi_imm", ImmExtD, 32'd5);
        chk("addi_pc4", PCPlus4D, 32'h4);

        // add x2,x1,x2 with same-cycle write of x1
        PCF = 32'h4; PCPlus4F = 32'h8;
        load(32'h00208133);
        RegWriteW = 1'b1; RdW = 5'd1; ResultW = 32'hDEADBEEF; StallD = 1'b1;
        #1;
        chk("byp_rd1", RD1D, 32'hDEADBEEF);
        chk("byp_rd2", RD2D, 32'h0);
        chk("add_rs1", 32'(Rs1D), 32'd1);
        chk("add_rs2", 32'(Rs2D), 32'd2);
        chk("add_rd", 32'(RdD), 32'd2);
        chk("add_alusrc", 32'(ALUSrcD), 32'd0);
        chk("add_imm", ImmExtD, 32'h0);
        step();
        RegWriteW = 1'b0;
        #1;
        chk("rf_rd1", RD1D, 32'hDEADBEEF);
        chk("stall_hold", InstrD, 32'h00208133);
        RegWriteW = 1'b1; RdW = 5'd2; ResultW = 32'h00000055;
        #1;
        chk("byp_rd2b", RD2D, 32'h00000055);
        step();
        RegWriteW = 1'b0;
        #1;
        chk("rf_rd2", RD2D, 32'h00000055);
        chk("rf_rd1_keep", RD1D, 32'hDEADBEEF);

        // writes to x0 are dropped and never bypassed
        StallD = 1'b0; PCF = 32'h8; PCPlus4F = 32'hC;
        load(32'h00000033);
        RegWriteW = 1'b1; RdW = 5'd0; ResultW = 32'h00001234;
        #1;
        chk("x0_rd1_pre", RD1D, 32'h0);
        chk("x0_rd2_pre", RD2D, 32'h0);
        step();
        RegWriteW = 1'b0;
        #1;
        chk("x0_rd1_post", RD1D, 32'h0);
        chk("x0_rd2_post", RD2D, 32'h0);

        // stall, then load, flush, and flush+stall
        PCF = 32'h100; PCPlus4F = 32'h104; StallD = 1'b1;
        load(32'hFE000EE3);
        chk("stall_instr", InstrD, 32'h00000033);
        chk("stall_pc", PCD, 32'h8);
        StallD = 1'b0;
        step();
        chk("beq_instr", InstrD, 32'hFE000EE3);
        chk("beq_pc", PCD, 32'h100);
        chk("beq_branch", 32'(BranchD), 32'd1);
        chk("beq_imm", ImmExtD, 32'hFFFFFFFC);
        chk("beq_aluctl", 32'(ALUControlD), 32'(ALU_SUB));
        chk("beq_regwrite", 32'(RegWriteD), 32'd0);
        FlushD = 1'b1;
        step();
        chk("flush_instr", InstrD, 32'h00000013);
        chk("flush_pc", PCD, 32'h0);
        chk("flush_pc4", PCPlus4D, 32'h0);
        FlushD = 1'b0;
        step();
        chk("reload_pc", PCD, 32'h100);
        StallD = 1'b1; FlushD = 1'b1;
        step();
        chk("fls_instr", InstrD, 32'h00000013);
        chk("fls_pc", PCD, 32'h0);
        StallD = 1'b0; FlushD = 1'b0;

        // jalr x0,-1(x0)
        load(32'hFFF00067);
        chk("jalr_jump", 32'(JumpD), 32'd1);
        chk("jalr_jalr", 32'(JalrD), 32'd1);
        chk("jalr_ressrc", 32'(ResultSrcD), 32'd2);
        chk("jalr_imm", ImmExtD, 32'hFFFFFFFF);

        // lui x1,0xABCDE
        load(32'hABCDE0B7);
        chk("lui_imm", ImmExtD, 32'hABCDE000);
        chk("lui_aluctl", 32'(ALUControlD), 32'(ALU_PASSB));
        chk("lui_alusrc", 32'(ALUSrcD), 32'd1);

        // sub x3,x1,x2
        load(32'h402081B3);
        chk("sub_aluctl", 32'(ALUControlD), 32'(ALU_SUB));
        // srai x5,x5,3
        load(32'h4032D293);
        chk("srai_aluctl", 32'(ALUControlD), 32'(ALU_SRA));
        chk("srai_imm", ImmExtD, 32'h00000403);
        // lw x6,8(x2)
        load(32'h00812303);
        chk("lw_ressrc", 32'(ResultSrcD), 32'd1);
        chk("lw_imm", ImmExtD, 32'h8);
        // sw x5,-4(x2)
        load(32'hFE512E23);
        chk("sw_memwrite", 32'(MemWriteD), 32'd1);
        chk("sw_regwrite", 32'(RegWriteD), 32'd0);
        chk("sw_imm", ImmExtD, 32'hFFFFFFFC);
        // jal x1,+8
        load(32'h008000EF);
        chk("jal_imm", ImmExtD, 32'h8);
        chk("jal_jalr", 32'(JalrD), 32'd0);
        chk("jal_ressrc", 32'(ResultSrcD), 32'd2);

        // unsupported opcode
        load(32'h0000307F);
        chk("unsup_regwrite", 32'(RegWriteD), 32'd0);
        chk("unsup_memwrite", 32'(MemWriteD), 32'd0);
        chk("unsup_jump", 32'(JumpD), 32'd0);
        chk("unsup_branch", 32'(BranchD), 32'd0);
`ifdef ID_ILLEGAL_DETECT_EN
        chk("unsup_illegal", 32'(IllegalD), 32'd1);
`endif
        // funct7=0000001 on OP
        load(32'h02000033);
`ifdef ID_ILLEGAL_DETECT_EN
        chk("f7_illegal", 32'(IllegalD), 32'd1);
        chk("f7_regwrite", 32'(RegWriteD), 32'd0);
        chk("f7_memwrite", 32'(MemWriteD), 32'd0);
`else
        chk("f7_regwrite", 32'(RegWriteD), 32'd1);
        chk("f7_aluctl", 32'(ALUControlD), 32'(ALU_ADD));
`endif

        // asynchronous reset mid-cycle clears pipeline register and register file
        PCF = 32'h200; PCPlus4F = 32'h204;
        load(32'h00208133);
        chk("pre_rst_rd1", RD1D, 32'hDEADBEEF);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_instr", InstrD, 32'h00000013);
        chk("arst_pc", PCD, 32'h0);
        @(negedge clk) reset = 1'b0;
        step();
        chk("arst_rf_rd1", RD1D, 32'h0);
        chk("arst_rf_rd2", RD2D, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode stage of the 5-stage RV32I pipeline. Sits directly downstream of the fetch stage and consumes InstrF, PCF and PCPlus4F.
- Contains the IF/ID pipeline register (with stall/flush), the main/ALU decoder, the immediate generator and the 32x32 register file.
- The register file has a write-back port and a same-cycle write-to-read bypass.
- Outputs feed the ID/EX register and the hazard unit.

Parameters:
- NOP_INSTR, 32'h00000013, instruction loaded into IF/ID on reset/flush (addi x0,x0,0)
- RF_DEPTH, 32, number of architectural registers (x0 hardwired to zero)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- StallD  in  1  high: hold IF/ID register contents
- FlushD  in  1  high: load bubble into IF/ID register
- InstrF  in  32  fetched instruction
- PCF  in  32  fetch PC
- PCPlus4F  in  32  fetch PC+4
- RegWriteW  in  1  write-back enable
- RdW  in  5  write-back destination
- ResultW  in  32  write-back data
- InstrD  out  32  registered instruction
- PCD  out  32  registered PC
- PCPlus4D  out  32  registered PC+4
- Rs1D, Rs2D, RdD  out  5  each; fields InstrD[19:15], [24:20], [11:7]
- RD1D, RD2D  out  32  register read data (bypassed)
- ImmExtD  out  32  sign-extended immediate
- RegWriteD  out  1  instruction writes rd
- ResultSrcD  out  2  00 ALU, 01 memory, 10 PC+4
- MemWriteD  out  1  store
- JumpD  out  1  jal/jalr
- BranchD  out  1  conditional branch
- ALUSrcD  out  1  1 = immediate operand B
- ALUControlD  out  4  ALU op code (package enum)
- JalrD  out  1  target = rs1+imm

Behaviour:
- IF/ID register
  - Asynchronous reset: InstrD=NOP_INSTR, PCD=0, PCPlus4D=0.
  - On each rising edge, priority is FlushD > StallD > load:
    - FlushD: InstrD=NOP_INSTR, PCD=0, PCPlus4D=0.
    - StallD: hold all three.
    - Otherwise: capture InstrF/PCF/PCPlus4F.
  - Flush and stall asserted together: flush wins.
  - Latency is 1 cycle from F to D.
- Decode
  - Purely combinational from InstrD.
  - Supported opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, FENCE (treated as NOP), SYSTEM (treated as NOP).
  - Unsupported opcode: all control outputs 0 (RegWriteD=0, MemWriteD=0, JumpD=0, BranchD=0).
  - Consequence: after reset, RegWriteD=1 with RdD=0, which is harmless.
- Immediate generation
  - Formats I/S/B/U/J, all sign-extended from InstrD[31].
  - B and J immediates have bit0=0.
  - U immediate is {InstrD[31:12],12'b0}.
  - R-type: ImmExtD=0.
- ALU control
  - Decoded from funct3/funct7[5].
  - SUB only for OP with funct7[5]=1. SRA/SRAI use funct7[5] for both OP and OP-IMM.
  - Branches drive the compare op (SUB for BEQ/BNE; SLT/SLTU for the signed/unsigned compares).
  - LUI drives pass-B; AUIPC drives ADD with ALUSrcD=1.
- Register file
  - Two async read ports, one write port.
  - Write on rising clk when RegWriteW && RdW!=0.
  - Reads of x0 always return 0.
  - Asynchronous reset clears all registers to 0.
- Bypass: if RegWriteW && RdW!=0 && RdW==Rs1D, then RD1D=ResultW; same rule for RD2D. This gives write-first semantics in the same cycle.
- Reset mid-operation: pipeline register and register file clear immediately and independently of StallD/FlushD.

Optional Feature:
- Macro ID_ILLEGAL_DETECT_EN.
- Defined:
  - Adds output IllegalD (1 bit).
  - IllegalD is asserted combinationally for an unsupported opcode, an illegal funct3 (e.g. BRANCH funct3 010/011, LOAD 011/110/111, STORE >010), or a bad funct7 (OP with funct7 not 0000000/0100000, or funct7=0100000 with funct3 other than 000/101).
  - While IllegalD=1, all control outputs are forced to 0.
  - IllegalD=0 after reset and flush.
- Undefined: port absent; only the unsupported-opcode rule applies, and illegal funct fields decode as their nearest legal op.

Decomposition:
- Package rv32i_pkg holds:
  - opcode constants (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_FENCE, OP_SYSTEM)
  - ALUControl enum (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, PASSB)
  - ImmSrc enum (I, S, B, U, J)
  - ResultSrc codes
  - NOP constant
- One sub-module, regfile_32x32: async reset, write port, two read ports with bypass.

Test Plan:
- Reset then release, StallD=FlushD=0, InstrF=32'h00500093, PCF=0 -> next cycle InstrD=32'h00500093, RegWriteD=1, ALUSrcD=1, ALUControlD=ADD, RdD=1, ImmExtD=5.
- RegWriteW=1, RdW=1, ResultW=32'hDEADBEEF while InstrD=32'h00208133 (add x2,x1,x2) -> same cycle RD1D=32'hDEADBEEF; after the edge, x1 reads 32'hDEADBEEF without bypass.
- RegWriteW=1, RdW=0, ResultW=32'h1234 while InstrD=32'h00000033 -> RD1D=RD2D=0 before and after the edge.
- Load InstrF=32'hFE000EE3 (beq x0,x0,-4) with StallD=1, then FlushD=1 -> stall holds the prior InstrD; flush yields InstrD=32'h00000013, PCD=0. With StallD=1 and FlushD=1 together, flush wins.
- InstrD=32'hFFF00067 -> JumpD=1, JalrD=1, ResultSrcD=10, ImmExtD=32'hFFFFFFFF. InstrD=32'hABCDE0B7 -> ImmExtD=32'hABCDE000, ALUControlD=PASSB.
- With ID_ILLEGAL_DETECT_EN, InstrD=32'h0000307F (unsupported opcode 1111111) and InstrD=32'h02000033 (funct7=0000001) -> IllegalD=1, RegWriteD=0, MemWriteD=0.
